// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the GPU command path: opcodes, per-opcode argument counts,
// reply status codes and the dispatcher state encoding.
package gpu_cmd_pkg;

   localparam logic [7:0] SYNC        = 8'hAA;

   localparam logic [7:0] OP_CLEAR    = 8'h01;
   localparam logic [7:0] OP_PIXEL    = 8'h02;
   localparam logic [7:0] OP_RECT     = 8'h03;
   localparam logic [7:0] OP_NOP      = 8'h10;
   localparam logic [7:0] OP_BRIGHT   = 8'h20;

   localparam logic [7:0] ST_OK       = 8'h00;
   localparam logic [7:0] ST_ERR_CRC  = 8'hE1;
   localparam logic [7:0] ST_ERR_LEN  = 8'hE2;
   localparam logic [7:0] ST_ERR_OP   = 8'hE3;
   localparam logic [7:0] ST_ERR_ARGC = 8'hE4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_ACK0,
      S_ACK1
   } disp_state_t;

   typedef struct packed {
      logic       known;
      logic [3:0] argc;
   } op_info_t;

   // Opcode table: whether the opcode exists and how many argument bytes it carries.
   function automatic op_info_t op_lookup(input logic [7:0] op);
      op_info_t info;
      info.known = 1'b1;
      info.argc  = 4'd0;
      case (op)
         OP_CLEAR:  info.argc = 4'd1;
         OP_PIXEL:  info.argc = 4'd5;
         OP_RECT:   info.argc = 4'd9;
         OP_NOP:    info.argc = 4'd0;
         OP_BRIGHT: info.argc = 4'd1;
         default:   info.known = 1'b0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Flop-based synchronous FIFO with show-ahead head output and registered count/full/empty.
module cmd_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [CNT_W-1:0] count_next;

   always_comb begin
      do_push    = push && !full;
      do_pop     = pop && !empty;
      count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   assign rdata = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_next;
         full  <= (count_next == CNT_W'(DEPTH));
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/cmd_dispatcher.sv
// Validates assembled frames, queues legal GPU commands and answers every accepted
// frame with a two-byte status reply on the UART TX handshake.
module cmd_dispatcher
   import gpu_cmd_pkg::*;
#(
   parameter int unsigned SIZE      = 256,
   parameter int unsigned MAX_ARGS  = 9,
   parameter int unsigned CMD_DEPTH = 4
) (
   input  logic                    CLK,
   input  logic                    rst,
   input  logic [8*SIZE-1:0]       packet,
   input  logic                    valid_packet,
   input  logic [8:0]              packet_len,
   input  logic                    err_len,
   input  logic                    err_crc,
   output logic                    fifo_ready,
   output logic                    fifo_full,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic [7:0]              cmd_opcode,
   output logic [8*MAX_ARGS-1:0]   cmd_args,
   output logic [3:0]              cmd_argc,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [7:0]              drop_cnt
);

   localparam int unsigned ARG_W   = 8 * MAX_ARGS;
   localparam int unsigned ENTRY_W = 8 + 4 + ARG_W;
   localparam int unsigned CNT_W   = $clog2(CMD_DEPTH + 1);

   disp_state_t      state;
   disp_state_t      state_d;

   logic [7:0]       op_q;
   logic [ARG_W-1:0] args_q;
   logic [8:0]       argc_q;
   logic             crc_bad_q;
   logic             len_bad_q;

   logic             capture;
   logic             drop;
   logic             push;
   logic             pop;
   logic [7:0]       status;
   op_info_t         info;
   logic [ARG_W-1:0] args_masked;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] count_next;
   logic             fifo_empty;
   logic [ENTRY_W-1:0] head;
   logic             tx_valid_d;
   logic [7:0]       tx_data_d;
   logic             fifo_ready_d;
   logic             unused_packet;

   // Header, sync and CRC bytes are already vetted by the assembler.
   assign unused_packet = ^{packet[15:0], packet[8*SIZE-1:8*(3+MAX_ARGS)]};

   assign pop        = cmd_valid && cmd_ready;
   assign cmd_valid  = !fifo_empty;
   assign cmd_opcode = head[ENTRY_W-1 -: 8];
   assign cmd_argc   = head[ARG_W +: 4];
   assign cmd_args   = head[ARG_W-1:0];

   // Frame verdict with fixed priority; bytes past the received count are zeroed.
   always_comb begin
      info        = op_lookup(op_q);
      args_masked = '0;
      if (crc_bad_q) begin
         status = ST_ERR_CRC;
      end else if (len_bad_q) begin
         status = ST_ERR_LEN;
      end else if (!info.known) begin
         status = ST_ERR_OP;
      end else if (argc_q != 9'(info.argc)) begin
         status = ST_ERR_ARGC;
      end else begin
         status = ST_OK;
      end
      for (int unsigned i = 0; i < MAX_ARGS; i++) begin
         if (9'(i) < argc_q) begin
            args_masked[8*i +: 8] = args_q[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d    = state;
      tx_valid_d = tx_valid;
      tx_data_d  = tx_data;
      capture    = 1'b0;
      push       = 1'b0;
      drop       = valid_packet && !fifo_ready;
      case (state)
         S_IDLE: begin
            if (valid_packet && fifo_ready) begin
               capture = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            push       = (status == ST_OK);
            state_d    = S_ACK0;
            tx_valid_d = 1'b1;
            tx_data_d  = status;
         end
         S_ACK0: begin
            if (tx_ready) begin
               state_d   = S_ACK1;
               tx_data_d = op_q;
            end
         end
         S_ACK1: begin
            if (tx_ready) begin
               state_d    = S_IDLE;
               tx_valid_d = 1'b0;
               tx_data_d  = 8'h00;
            end
         end
         default: state_d = S_IDLE;
      endcase
      count_next   = fifo_count + CNT_W'(push) - CNT_W'(pop);
      fifo_ready_d = (state_d == S_IDLE) && (count_next != CNT_W'(CMD_DEPTH));
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         op_q       <= '0;
         args_q     <= '0;
         argc_q     <= '0;
         crc_bad_q  <= 1'b0;
         len_bad_q  <= 1'b0;
         tx_valid   <= 1'b0;
         tx_data    <= 8'h00;
         fifo_ready <= 1'b1;
         drop_cnt   <= 8'h00;
      end else begin
         tx_valid   <= tx_valid_d;
         tx_data    <= tx_data_d;
         fifo_ready <= fifo_ready_d;
         if (capture) begin
            op_q      <= packet[23:16];
            args_q    <= packet[24 +: ARG_W];
            argc_q    <= packet_len - 9'd4;
            crc_bad_q <= err_crc;
            len_bad_q <= err_len || (packet_len < 9'd4);
         end
         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (rst),
      .push  (push),
      .wdata ({op_q, info.argc, args_masked}),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher: expected replies and commands are queued at
// stimulus time and compared by an independent monitor on each handshake.
module tb_cmd_dispatcher;
   import gpu_cmd_pkg::*;

   localparam int SIZE      = 256;
   localparam int MAX_ARGS  = 9;
   localparam int CMD_DEPTH = 4;

   logic                  CLK = 1'b0;
   logic                  rst;
   logic [8*SIZE-1:0]     packet;
   logic                  valid_packet;
   logic [8:0]            packet_len;
   logic                  err_len;
   logic                  err_crc;
   logic                  fifo_ready;
   logic                  fifo_full;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [7:0]            cmd_opcode;
   logic [8*MAX_ARGS-1:0] cmd_args;
   logic [3:0]            cmd_argc;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [7:0]            drop_cnt;

   typedef struct {
      logic [7:0]            op;
      logic [3:0]            argc;
      logic [8*MAX_ARGS-1:0] args;
   } cmd_t;

   logic [7:0] tx_q [$];
   cmd_t       cmd_q [$];
   int         argc_tbl [logic [7:0]];
   int         tests = 0;
   int         fails = 0;
   int         pushes = 0;
   int         pops = 0;
   int         drops_model = 0;
   bit         rnd_en = 1'b0;

   cmd_dispatcher #(
      .SIZE      (SIZE),
      .MAX_ARGS  (MAX_ARGS),
      .CMD_DEPTH (CMD_DEPTH)
   ) dut (
      .CLK          (CLK),
      .rst          (rst),
      .packet       (packet),
      .valid_packet (valid_packet),
      .packet_len   (packet_len),
      .err_len      (err_len),
      .err_crc      (err_crc),
      .fifo_ready   (fifo_ready),
      .fifo_full    (fifo_full),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_args     (cmd_args),
      .cmd_argc     (cmd_argc),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .drop_cnt     (drop_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference verdict straight from the frame rules.
   function automatic logic [7:0] ref_status(input logic [7:0] op, input int plen,
                                             input bit ec, input bit el);
      if (ec) return 8'hE1;
      if (el || plen < 4) return 8'hE2;
      if (!argc_tbl.exists(op)) return 8'hE3;
      if (plen - 4 != argc_tbl[op]) return 8'hE4;
      return 8'h00;
   endfunction

   function automatic logic [8*SIZE-1:0] build_packet(input logic [7:0] op,
                                                      input logic [8*MAX_ARGS-1:0] raw,
                                                      input int plen);
      logic [8*SIZE-1:0] p;
      for (int k = 0; k < SIZE; k++) p[8*k +: 8] = 8'($urandom);
      p[7:0]   = SYNC;
      p[15:8]  = 8'(plen - 2);
      p[23:16] = op;
      p[24 +: 8*MAX_ARGS] = raw;
      return p;
   endfunction

   task automatic send_frame(input logic [7:0] op, input logic [8*MAX_ARGS-1:0] raw,
                             input int plen, input bit ec, input bit el, input bit busy,
                             output bit accepted);
      logic [7:0] st;
      cmd_t       c;
      packet       = build_packet(op, raw, plen);
      packet_len   = 9'(plen);
      err_crc      = ec;
      err_len      = el;
      valid_packet = 1'b1;
      accepted     = !busy && ((pushes - pops) < CMD_DEPTH);
      if (accepted) begin
         st = ref_status(op, plen, ec, el);
         tx_q.push_back(st);
         tx_q.push_back(op);
         if (st == 8'h00) begin
            c.op   = op;
            c.argc = 4'(argc_tbl[op]);
            c.args = '0;
            for (int i = 0; i < argc_tbl[op]; i++) c.args[8*i +: 8] = raw[8*i +: 8];
            cmd_q.push_back(c);
            pushes++;
         end
      end else if (drops_model < 255) begin
         drops_model++;
      end
      @(posedge CLK); #1;
      valid_packet = 1'b0;
      err_crc      = 1'b0;
      err_len      = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (tx_q.size() != 0 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (tx_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL reply_timeout: %0d bytes pending, expected 0", tx_q.size());
      end
      @(posedge CLK); #1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (cmd_q.size() != 0 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (cmd_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d commands pending, expected 0", cmd_q.size());
      end
      @(posedge CLK); #1;
   endtask

   // Monitor: compare every completed handshake against the head of its scoreboard queue.
   always @(negedge CLK) begin
      if (!rst) begin
         if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_unexpected: byte %0h seen, no reply expected", tx_data);
            end else begin
               check("tx_byte", 128'(tx_data), 128'(tx_q.pop_front()));
            end
         end
         if (cmd_valid && cmd_ready) begin
            pops++;
            if (cmd_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL cmd_unexpected: opcode %0h seen, no command expected", cmd_opcode);
            end else begin
               cmd_t c;
               c = cmd_q.pop_front();
               check("cmd_opcode", 128'(cmd_opcode), 128'(c.op));
               check("cmd_argc", 128'(cmd_argc), 128'(c.argc));
               check("cmd_args", 128'(cmd_args), 128'(c.args));
            end
         end
      end
   end

   // Random handshake pressure from the consumers.
   initial begin
      forever begin
         @(posedge CLK); #1;
         if (rnd_en) begin
            tx_ready  = ($urandom_range(0, 3) != 0);
            cmd_ready = ($urandom_range(0, 2) != 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8*MAX_ARGS-1:0] raw;
      logic [7:0]            ops [5];
      logic [7:0]            op;
      int                    plen;
      bit                    acc;
      bit                    acc2;

      argc_tbl[8'h01] = 1;
      argc_tbl[8'h02] = 5;
      argc_tbl[8'h03] = 9;
      argc_tbl[8'h10] = 0;
      argc_tbl[8'h20] = 1;
      ops = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h20};

      rst          = 1'b1;
      packet       = '0;
      valid_packet = 1'b0;
      packet_len   = '0;
      err_len      = 1'b0;
      err_crc      = 1'b0;
      cmd_ready    = 1'b1;
      tx_ready     = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      rst = 1'b0;

      check("rst_fifo_ready", 128'(fifo_ready), 128'(1));
      check("rst_fifo_full", 128'(fifo_full), 128'(0));
      check("rst_cmd_valid", 128'(cmd_valid), 128'(0));
      check("rst_tx_valid", 128'(tx_valid), 128'(0));
      check("rst_tx_data", 128'(tx_data), 128'(0));
      check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
      check("rst_cmd_fields", 128'({cmd_opcode, cmd_argc, cmd_args}), 128'(0));

      // CLEAR with latency check: command and reply appear two cycles after the strobe.
      raw = {8'($urandom), 64'({$urandom, $urandom})};
      raw[7:0] = 8'h0F;
      send_frame(8'h01, raw, 5, 1'b0, 1'b0, 1'b0, acc);
      check("lat_cmd_valid_n1", 128'(cmd_valid), 128'(0));
      check("lat_tx_valid_n1", 128'(tx_valid), 128'(0));
      @(posedge CLK); #1;
      check("lat_cmd_valid_n2", 128'(cmd_valid), 128'(1));
      check("lat_tx_valid_n2", 128'(tx_valid), 128'(1));
      wait_idle();

      send_frame(8'h03, 72'h05_00_28_00_1E_00_14_00_0A, 13, 1'b0, 1'b0, 1'b0, acc);
      wait_idle();
      raw = '1;
      send_frame(8'h20, raw, 5, 1'b1, 1'b0, 1'b0, acc);
      wait_idle();
      send_frame(8'h7E, raw, 6, 1'b0, 1'b0, 1'b0, acc);
      wait_idle();
      send_frame(8'h01, raw, 6, 1'b0, 1'b0, 1'b0, acc);
      wait_idle();
      send_frame(8'h10, raw, 4, 1'b0, 1'b1, 1'b0, acc);
      wait_idle();
      send_frame(8'h10, raw, 3, 1'b0, 1'b0, 1'b0, acc);
      wait_idle();
      send_frame(8'h10, raw, 4, 1'b0, 1'b0, 1'b0, acc);
      wait_idle();
      wait_drain();

      // Fill the FIFO with the consumer stalled; the fifth frame must be dropped.
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         raw = '0;
         raw[7:0] = 8'(8'h11 + i);
         send_frame(8'h01, raw, 5, 1'b0, 1'b0, 1'b0, acc);
         wait_idle();
         if (i == 3) begin
            check("full_fifo_full", 128'(fifo_full), 128'(1));
            check("full_fifo_ready", 128'(fifo_ready), 128'(0));
         end
      end
      check("full_drop_cnt", 128'(drop_cnt), 128'(drops_model));
      cmd_ready = 1'b1;
      wait_drain();
      check("drain_fifo_ready", 128'(fifo_ready), 128'(1));

      // Stall the reply, then reset in the middle of it.
      cmd_ready = 1'b0;
      tx_ready  = 1'b0;
      send_frame(8'h01, raw, 5, 1'b0, 1'b0, 1'b0, acc);
      @(posedge CLK); #1;
      for (int i = 0; i < 50; i++) begin
         check("hold_tx_valid", 128'(tx_valid), 128'(1));
         check("hold_tx_data", 128'(tx_data), 128'(0));
         check("hold_fifo_ready", 128'(fifo_ready), 128'(0));
         @(posedge CLK); #1;
      end
      rst = 1'b1;
      @(posedge CLK); #1;
      rst = 1'b0;
      check("midrst_tx_valid", 128'(tx_valid), 128'(0));
      check("midrst_cmd_valid", 128'(cmd_valid), 128'(0));
      check("midrst_fifo_ready", 128'(fifo_ready), 128'(1));
      check("midrst_drop_cnt", 128'(drop_cnt), 128'(0));
      tx_q.delete();
      cmd_q.delete();
      pushes      = 0;
      pops        = 0;
      drops_model = 0;
      tx_ready    = 1'b1;
      cmd_ready   = 1'b1;

      // Randomized frames under random back-pressure.
      rnd_en = 1'b1;
      for (int n = 0; n < 150; n++) begin
         int sel;
         int r;
         sel = int'($urandom_range(0, 5));
         op  = (sel == 5) ? 8'($urandom) : ops[sel];
         plen = argc_tbl.exists(op) ? argc_tbl[op] + 4 : int'($urandom_range(4, 13));
         r = int'($urandom_range(0, 9));
         if (r == 0) plen = plen + 1;
         if (r == 1) plen = int'($urandom_range(0, 3));
         raw = {8'($urandom), 64'({$urandom, $urandom})};
         send_frame(op, raw, plen, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    1'b0, acc);
         if (acc && $urandom_range(0, 7) == 0) begin
            send_frame(8'h01, raw, 5, 1'b0, 1'b0, 1'b1, acc2);
         end
         wait_idle();
      end
      rnd_en    = 1'b0;
      tx_ready  = 1'b1;
      cmd_ready = 1'b1;
      wait_drain();
      check("rand_drop_cnt", 128'(drop_cnt), 128'(drops_model));

      // Saturate the drop counter while the reply is stalled.
      tx_ready = 1'b0;
      send_frame(8'h20, raw, 5, 1'b0, 1'b0, 1'b0, acc);
      for (int i = 0; i < 260; i++) begin
         send_frame(8'h01, raw, 5, 1'b0, 1'b0, 1'b1, acc2);
      end
      check("sat_drop_cnt", 128'(drop_cnt), 128'(drops_model));
      tx_ready = 1'b1;
      wait_idle();
      wait_drain();
      check("end_tx_queue", 128'(tx_q.size()), 128'(0));
      check("end_cmd_queue", 128'(cmd_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
